// File: rtl/vehicle_data_receiver_if.sv
// Received-frame AXI4-Stream link from the CAN controller to the vehicle data receiver.
// The master drives the frame and the slave answers with tready.
interface vehicle_data_receiver_if;
    logic [63:0] tdata;
    logic [10:0] tid;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tid, tkeep, tvalid, input tready);
    modport slave  (input tdata, tid, tkeep, tvalid, output tready);
endinterface

// File: rtl/vehicle_data_receiver.sv
// Vehicle CAN receive decoder: filters frames by ID, unpacks engine rev, battery and speed
// into held registers, and drops each message's valid flag when it stops arriving.
module vehicle_data_receiver #(
    parameter int unsigned TIMEOUT_CYCLE = 150_000_000,
    parameter logic [10:0] ID_ENGINE_REV = 11'h3D9,
    parameter logic [10:0] ID_CAR_SPEED  = 11'h3E9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vehicle_data_receiver_if.slave stm_recv_data_in,
    output logic [13:0]            engine_rev,
    output logic [7:0]             battery_value,
    output logic [8:0]             vehicle_speed,
    output logic                   engine_valid,
    output logic                   speed_valid,
    output logic                   engine_update,
    output logic                   speed_update,
    output logic [7:0]             dlc_error_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLE + 1);
    localparam logic [CNT_W-1:0] EXPIRE = CNT_W'(TIMEOUT_CYCLE - 1);

    typedef enum logic {IDLE, DECODE} state_t;

    state_t           state;
    logic             tready_q;
    // Only payload bits [63:34] carry fields; the rest are reserved in both frames.
    logic [29:0]      buf_payload;
    logic [10:0]      buf_id;
    logic [7:0]       buf_keep;
    logic             engine_hit;
    logic             speed_hit;
    logic             dlc_bad;
    logic [CNT_W-1:0] engine_cnt;
    logic [CNT_W-1:0] speed_cnt;

    assign stm_recv_data_in.tready = tready_q;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        engine_hit = 1'b0;
        speed_hit  = 1'b0;
        dlc_bad    = 1'b0;
        if (state == DECODE && (buf_id == ID_ENGINE_REV || buf_id == ID_CAR_SPEED)) begin
            if (buf_keep == 8'hFF) begin
                engine_hit = (buf_id == ID_ENGINE_REV);
                speed_hit  = (buf_id == ID_CAR_SPEED);
            end else begin
                dlc_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            tready_q        <= 1'b1;
            buf_payload     <= '0;
            buf_id          <= '0;
            buf_keep        <= '0;
            engine_rev      <= '0;
            battery_value   <= '0;
            vehicle_speed   <= '0;
            engine_update   <= 1'b0;
            speed_update    <= 1'b0;
            dlc_error_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            engine_update <= engine_hit;
            speed_update  <= speed_hit;
            case (state)
                IDLE: begin
                    if (stm_recv_data_in.tvalid && tready_q) begin
                        buf_payload <= stm_recv_data_in.tdata[63:34];
                        buf_id      <= stm_recv_data_in.tid;
                        buf_keep    <= stm_recv_data_in.tkeep;
                        state       <= DECODE;
                        tready_q    <= 1'b0;
                    end
                end
                DECODE: begin
                    state    <= IDLE;
                    tready_q <= 1'b1;
                    if (engine_hit) begin
                        battery_value <= buf_payload[21:14];
                        engine_rev    <= buf_payload[13:0];
                    end
                    if (speed_hit) begin
                        vehicle_speed <= buf_payload[29:21];
                    end
                    if (dlc_bad && dlc_error_count != 8'hFF) begin
                        dlc_error_count <= dlc_error_count + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tready_q <= 1'b1;
                end
            endcase
        end
    end

    // Staleness: a fresh update always beats expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            engine_valid <= 1'b0;
            speed_valid  <= 1'b0;
            engine_cnt   <= '0;
            speed_cnt    <= '0;
        end else begin
            if (engine_hit) begin
                engine_valid <= 1'b1;
                engine_cnt   <= '0;
            end else if (engine_valid) begin
                if (engine_cnt == EXPIRE) engine_valid <= 1'b0;
                else                      engine_cnt   <= engine_cnt + 1'b1;
            end

            if (speed_hit) begin
                speed_valid <= 1'b1;
                speed_cnt   <= '0;
            end else if (speed_valid) begin
                if (speed_cnt == EXPIRE) speed_valid <= 1'b0;
                else                     speed_cnt   <= speed_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vehicle_data_receiver.sv
// Self-checking bench for vehicle_data_receiver: table-driven decode vectors, a pulse-driven
// scoreboard, and hand-written timeout, streaming, saturation and reset sequences.
module tb_vehicle_data_receiver;

    localparam int unsigned TIMEOUT = 16;
    localparam logic [10:0] ID_ENG = 11'h3D9;
    localparam logic [10:0] ID_SPD = 11'h3E9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vehicle_data_receiver_if rx();

    logic [13:0] engine_rev;
    logic [7:0]  battery_value;
    logic [8:0]  vehicle_speed;
    logic        engine_valid;
    logic        speed_valid;
    logic        engine_update;
    logic        speed_update;
    logic [7:0]  dlc_error_count;

    vehicle_data_receiver #(
        .TIMEOUT_CYCLE(TIMEOUT),
        .ID_ENGINE_REV(ID_ENG),
        .ID_CAR_SPEED (ID_SPD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stm_recv_data_in(rx),
        .engine_rev      (engine_rev),
        .battery_value   (battery_value),
        .vehicle_speed   (vehicle_speed),
        .engine_valid    (engine_valid),
        .speed_valid     (speed_valid),
        .engine_update   (engine_update),
        .speed_update    (speed_update),
        .dlc_error_count (dlc_error_count)
    );

    typedef struct {
        logic [10:0] id;
        logic [7:0]  keep;
        logic [63:0] data;
        logic        eu;
        logic        su;
        logic [13:0] rev;
        logic [7:0]  bat;
        logic [8:0]  spd;
        logic [7:0]  dlc;
    } vec_t;

    int tests = 0;
    int fails = 0;
    logic [21:0] eng_q[$];
    logic [8:0]  spd_q[$];
    logic prev_eng = 1'b0;
    logic prev_spd = 1'b0;
    int eng_pulses = 0;
    int spd_pulses = 0;
    bit alt_mode = 1'b0;
    int last_kind = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance to the next falling edge and score any update pulse seen there.
    task automatic tick();
        logic [21:0] e;
        logic [8:0]  s;
        @(negedge clk);
        if (engine_update || speed_update)
            check("pulse_exclusive", 64'(engine_update & speed_update), 64'd0);
        if (engine_update) begin
            eng_pulses++;
            check("eng_pulse_width", 64'(prev_eng), 64'd0);
            if (alt_mode && last_kind != 0) check("pulse_alternate", 64'(last_kind), 64'd2);
            last_kind = 1;
            if (eng_q.size() == 0) begin
                check("eng_unexpected_update", 64'd1, 64'd0);
            end else begin
                e = eng_q.pop_front();
                check("sb_engine_rev", 64'(engine_rev), 64'(e[21:8]));
                check("sb_battery", 64'(battery_value), 64'(e[7:0]));
                check("sb_engine_valid", 64'(engine_valid), 64'd1);
            end
        end
        if (speed_update) begin
            spd_pulses++;
            check("spd_pulse_width", 64'(prev_spd), 64'd0);
            if (alt_mode && last_kind != 0) check("pulse_alternate", 64'(last_kind), 64'd1);
            last_kind = 2;
            if (spd_q.size() == 0) begin
                check("spd_unexpected_update", 64'd1, 64'd0);
            end else begin
                s = spd_q.pop_front();
                check("sb_vehicle_speed", 64'(vehicle_speed), 64'(s));
                check("sb_speed_valid", 64'(speed_valid), 64'd1);
            end
        end
        prev_eng = engine_update;
        prev_spd = speed_update;
    endtask

    // Present a frame, leave tvalid high, return one edge after the accepting edge.
    task automatic send(input logic [10:0] id, input logic [7:0] keep, input logic [63:0] data,
                        input bit apply, output int waited);
        bit accepted;
        accepted = 1'b0;
        waited = 0;
        rx.tid = id;
        rx.tkeep = keep;
        rx.tdata = data;
        rx.tvalid = 1'b1;
        if (apply && keep == 8'hFF) begin
            if (id == ID_ENG) eng_q.push_back({data[47:34], data[55:48]});
            else if (id == ID_SPD) spd_q.push_back(data[63:55]);
        end
        while (!accepted && waited < 8) begin
            accepted = rx.tready;
            tick();
            waited++;
        end
        if (!accepted) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rx.tvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tready"}, 64'(rx.tready), 64'd1);
        check({tag, "_engine_rev"}, 64'(engine_rev), 64'd0);
        check({tag, "_battery"}, 64'(battery_value), 64'd0);
        check({tag, "_speed"}, 64'(vehicle_speed), 64'd0);
        check({tag, "_valids"}, 64'({engine_valid, speed_valid}), 64'd0);
        check({tag, "_pulses"}, 64'({engine_update, speed_update}), 64'd0);
        check({tag, "_dlc"}, 64'(dlc_error_count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        int w;
        int k;

        vecs[0] = '{ID_ENG,  8'hFF, {8'h00, 8'h5A, 14'h2710, 34'h0},
                    1'b1, 1'b0, 14'd10000, 8'h5A, 9'd0, 8'd0};
        vecs[1] = '{ID_SPD,  8'hFF, {9'd200, 55'h7F_FFFF_FFFF_FFFF},
                    1'b0, 1'b1, 14'd10000, 8'h5A, 9'd200, 8'd0};
        vecs[2] = '{11'h123, 8'hFF, 64'hDEAD_BEEF_0123_4567,
                    1'b0, 1'b0, 14'd10000, 8'h5A, 9'd200, 8'd0};
        vecs[3] = '{ID_ENG,  8'h0F, {8'h00, 8'h11, 14'h0042, 34'h0},
                    1'b0, 1'b0, 14'd10000, 8'h5A, 9'd200, 8'd1};
        vecs[4] = '{ID_SPD,  8'hFE, {9'd3, 55'h0},
                    1'b0, 1'b0, 14'd10000, 8'h5A, 9'd200, 8'd2};
        vecs[5] = '{11'h123, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b0, 1'b0, 14'd10000, 8'h5A, 9'd200, 8'd2};
        vecs[6] = '{ID_ENG,  8'hFF, {8'hFF, 8'h11, 14'h3FFF, 34'h3_FFFF_FFFF},
                    1'b1, 1'b0, 14'h3FFF, 8'h11, 9'd200, 8'd2};
        vecs[7] = '{ID_SPD,  8'hFF, {9'h1FF, 55'h0},
                    1'b0, 1'b1, 14'h3FFF, 8'h11, 9'd511, 8'd2};
        vecs[8] = '{ID_SPD,  8'hFF, {9'd0, 55'h55_5555_5555_5555},
                    1'b0, 1'b1, 14'h3FFF, 8'h11, 9'd0, 8'd2};

        rx.tvalid = 1'b0;
        rx.tid = '0;
        rx.tkeep = '0;
        rx.tdata = '0;
        tick();
        tick();
        check_reset_values("in_reset");
        rst_n = 1'b1;
        tick();
        check_reset_values("after_release");

        // Decode table: tready low only at N+1, results visible at N+2.
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].id, vecs[i].keep, vecs[i].data, 1'b1, w);
            rx.tvalid = 1'b0;
            check($sformatf("v%0d_tready_n1", i), 64'(rx.tready), 64'd0);
            check($sformatf("v%0d_pulse_n1", i), 64'({engine_update, speed_update}), 64'd0);
            tick();
            check($sformatf("v%0d_tready_n2", i), 64'(rx.tready), 64'd1);
            check($sformatf("v%0d_eng_update", i), 64'(engine_update), 64'(vecs[i].eu));
            check($sformatf("v%0d_spd_update", i), 64'(speed_update), 64'(vecs[i].su));
            check($sformatf("v%0d_engine_rev", i), 64'(engine_rev), 64'(vecs[i].rev));
            check($sformatf("v%0d_battery", i), 64'(battery_value), 64'(vecs[i].bat));
            check($sformatf("v%0d_speed", i), 64'(vehicle_speed), 64'(vecs[i].spd));
            check($sformatf("v%0d_dlc", i), 64'(dlc_error_count), 64'(vecs[i].dlc));
            tick();
        end

        // Timeout: valid drops exactly TIMEOUT cycles after it became visible.
        do_reset();
        send(ID_ENG, 8'hFF, {8'h00, 8'h5A, 14'h2710, 34'h0}, 1'b1, w);
        rx.tvalid = 1'b0;
        tick();
        check("to_valid_rise", 64'(engine_valid), 64'd1);
        k = 0;
        while (engine_valid && k < 40) begin
            tick();
            k++;
        end
        check("to_cycles", 64'(k), 64'(TIMEOUT));
        check("to_rev_held", 64'(engine_rev), 64'd10000);
        check("to_bat_held", 64'(battery_value), 64'h5A);
        tick();
        tick();
        check("to_stays_low", 64'(engine_valid), 64'd0);

        // Update landing in the expiry cycle keeps valid high.
        send(ID_ENG, 8'hFF, {8'h00, 8'h33, 14'd1234, 34'h0}, 1'b1, w);
        rx.tvalid = 1'b0;
        tick();
        check("col_valid_rise", 64'(engine_valid), 64'd1);
        for (int j = 1; j <= 14; j++) begin
            tick();
            check($sformatf("col_hold_%0d", j), 64'(engine_valid), 64'd1);
        end
        send(ID_ENG, 8'hFF, {8'h00, 8'h44, 14'd4321, 34'h0}, 1'b1, w);
        rx.tvalid = 1'b0;
        check("col_expiry_cycle", 64'(engine_valid), 64'd1);
        tick();
        check("col_update_cycle", 64'(engine_valid), 64'd1);
        check("col_update_pulse", 64'(engine_update), 64'd1);
        for (int j = 1; j <= 10; j++) begin
            tick();
            check($sformatf("col_after_%0d", j), 64'(engine_valid), 64'd1);
        end

        // Back-to-back streaming with tvalid held high.
        do_reset();
        eng_pulses = 0;
        spd_pulses = 0;
        alt_mode = 1'b1;
        last_kind = 0;
        for (int i = 0; i < 6; i++) begin
            logic [7:0]  bat;
            logic [13:0] rev;
            logic [8:0]  spd;
            bat = 8'(i * 7 + 1);
            rev = 14'(1000 + i);
            spd = 9'(100 + i);
            if (i % 2 == 0) send(ID_ENG, 8'hFF, {8'h00, bat, rev, 34'h0}, 1'b1, w);
            else            send(ID_SPD, 8'hFF, {spd, 55'h0}, 1'b1, w);
            check($sformatf("b2b_interval_%0d", i), 64'(w), (i == 0) ? 64'd1 : 64'd2);
        end
        rx.tvalid = 1'b0;
        tick();
        tick();
        tick();
        check("b2b_eng_pulses", 64'(eng_pulses), 64'd3);
        check("b2b_spd_pulses", 64'(spd_pulses), 64'd3);
        alt_mode = 1'b0;

        // DLC error counter saturates.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send((i % 2 == 0) ? ID_ENG : ID_SPD, (i % 3 == 0) ? 8'h00 : 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
            if (i == 254) check("dlc_254", 64'(dlc_error_count), 64'hFE);
            if (i == 255) check("dlc_255", 64'(dlc_error_count), 64'hFF);
        end
        rx.tvalid = 1'b0;
        tick();
        tick();
        check("dlc_saturated", 64'(dlc_error_count), 64'hFF);
        check("dlc_no_data", 64'({engine_rev, vehicle_speed}), 64'd0);
        check("dlc_no_valid", 64'({engine_valid, speed_valid}), 64'd0);

        // Reset during DECODE discards the in-flight frame.
        do_reset();
        send(ID_SPD, 8'hFF, {9'd77, 55'h0}, 1'b1, w);
        rx.tvalid = 1'b0;
        tick();
        tick();
        send(ID_ENG, 8'hFF, {8'h00, 8'h66, 14'd555, 34'h0}, 1'b1, w);
        rx.tvalid = 1'b0;
        tick();
        tick();
        send(ID_ENG, 8'h01, 64'h0, 1'b1, w);
        rx.tvalid = 1'b0;
        tick();
        tick();
        check("pre_rst_state", 64'({engine_rev, battery_value, vehicle_speed, dlc_error_count}),
              64'({14'd555, 8'h66, 9'd77, 8'd1}));
        send(ID_ENG, 8'hFF, {8'h00, 8'h77, 14'd999, 34'h0}, 1'b0, w);
        rx.tvalid = 1'b0;
        check("mid_decode_tready", 64'(rx.tready), 64'd0);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_rst");
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) tick();
        check("post_rst_rev", 64'(engine_rev), 64'd0);
        check("post_rst_valid", 64'(engine_valid), 64'd0);
        check("post_rst_tready", 64'(rx.tready), 64'd1);

        check("eng_q_drained", 64'(eng_q.size()), 64'd0);
        check("spd_q_drained", 64'(spd_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vehicle_data_receiver.md
# vehicle_data_receiver

Receive-side decoder for the cart's vehicle CAN messages. Sits downstream of the CAN controller's received-frame AXI4-Stream output. Filters frames by ID, unpacks engine revolution, battery level and vehicle speed into held registers, and flags each message stale when it stops arriving. Its field layout is the exact inverse of the team's vehicle data transmitter, so a dashboard/monitor node can consume the transmitter's output directly.

## Interface
Parameters:
- TIMEOUT_CYCLE, 150_000_000: cycles without a valid frame before that message's valid flag drops.
- ID_ENGINE_REV, 11'h3D9: ID of the engine-rev/battery frame.
- ID_CAR_SPEED, 11'h3E9: ID of the vehicle-speed frame.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - rst_n  in  1  asynchronous active-low reset.
- Received-frame AXI4-Stream input:
  - stm_recv_data_in_tdata  in  64  frame payload, byte 0 in [63:56].
  - stm_recv_data_in_tid  in  11  frame ID.
  - stm_recv_data_in_tkeep  in  8  payload size mask.
  - stm_recv_data_in_tvalid  in  1  frame valid.
  - stm_recv_data_in_tready  out  1  high only in IDLE.
- Decoded outputs:
  - engine_rev  out  14  last engine revolution.
  - battery_value  out  8  last battery level.
  - vehicle_speed  out  9  last vehicle speed.
  - engine_valid  out  1  engine frame received within TIMEOUT_CYCLE.
  - speed_valid  out  1  speed frame received within TIMEOUT_CYCLE.
  - engine_update  out  1  one-cycle pulse on each engine-register update.
  - speed_update  out  1  one-cycle pulse on each speed-register update.
  - dlc_error_count  out  8  saturating count of frames with a matching ID and a bad tkeep.

## Operation
- States: IDLE (tready=1) and DECODE (tready=0).
- IDLE: on tvalid&tready, latch tdata/tid/tkeep into a frame buffer and go to DECODE.
- DECODE: evaluate the buffered frame, then always return to IDLE after one cycle.
- Engine frame: tid==ID_ENGINE_REV and tkeep==8'hFF.
  - battery_value<=tdata[55:48] and engine_rev<=tdata[47:34].
  - engine_update pulses, engine_valid<=1, engine timeout counter<=0.
- Speed frame: tid==ID_CAR_SPEED and tkeep==8'hFF.
  - vehicle_speed<=tdata[63:55].
  - speed_update pulses, speed_valid<=1, speed timeout counter<=0.
- Reserved payload bits are ignored: [63:56] and [33:0] for engine, [54:0] for speed.
- Matching ID with tkeep!=8'hFF:
  - No register update, no pulse, valid flag and counter unaffected.
  - dlc_error_count increments, saturating at 8'hFF.
- Non-matching ID: frame consumed and discarded, no other effect.
- Timeout, one independent counter per message, width $clog2(TIMEOUT_CYCLE+1):
  - Counter increments each cycle while its valid flag is 1.
  - If the counter equals TIMEOUT_CYCLE-1 and no update happens that cycle, valid<=0 and the counter holds.
  - Data registers keep their last value after timeout.
  - An update in the same cycle as expiry wins: valid stays 1, counter<=0.
- Reset (asynchronous, any time, including mid-DECODE):
  - State returns to IDLE and the buffer is cleared; the in-flight frame is lost.

## Timing
- Reset values:
  - tready=1.
  - engine_rev=0, battery_value=0, vehicle_speed=0.
  - engine_valid=0, speed_valid=0, both update pulses=0.
  - dlc_error_count=0, timeout counters=0.
- Handshake in cycle N, then:
  - Cycle N+1: DECODE, tready=0.
  - Cycle N+2: updated data, valid=1 and update pulse are visible; tready=1 again.
- Throughput: at most one frame every 2 cycles. An upstream tvalid held during DECODE waits; it is not dropped.
- update pulses are exactly one cycle wide. engine_update and speed_update never assert in the same cycle.
- Expiry: valid deasserts exactly TIMEOUT_CYCLE cycles after the cycle in which the update became visible, provided no further update arrives.

## Test plan
- Engine frame decode:
  - Stimulus: tid=3D9, tkeep=FF, [55:48]=5A, [47:34]=14'h2710, all other bits 0.
  - Required response: at N+2, battery_value=5A, engine_rev=10000, engine_valid=1, one-cycle engine_update; tready low only at N+1.
- Speed frame decode:
  - Stimulus: tid=3E9, tkeep=FF, [63:55]=9'd200, reserved bits 1.
  - Required response: vehicle_speed=200, speed_valid=1; engine outputs unchanged.
- Filtering and DLC errors:
  - Stimulus: frame with tid=123, then tid=3D9 with tkeep=0F.
  - Required response: no register change; dlc_error_count=1. After 300 bad frames the count holds at FF.
- Timeout (TIMEOUT_CYCLE=16):
  - Stimulus: one engine frame, then silence.
  - Required response: engine_valid falls 16 cycles after it rose; engine_rev holds 10000.
  - Stimulus: a frame timed so its update lands in the expiry cycle.
  - Required response: engine_valid never drops.
- Back-to-back streaming:
  - Stimulus: tvalid held high with alternating 3D9/3E9 frames.
  - Required response: one accept every 2 cycles, none lost, pulses alternate.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during DECODE of an engine frame.
  - Required response: all outputs at reset values immediately; the frame is not applied after release.
